// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among NUM_PORTS requesters.
// A two-state FSM (IDLE/BUSY) keeps exactly one memory transaction in flight.
// The winner's command and fields are latched at grant and held until mem_resp.
// Arbitration is either fixed priority (lowest index wins) or round-robin.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   req_byte_enable,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic [BE_WIDTH-1:0]             mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_resp,
  output logic                            grant_valid,
  output logic [IDX_WIDTH-1:0]            grant_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   last_grant;
  logic [NUM_PORTS-1:0]   requesting;
  logic                   win_found;
  logic [IDX_WIDTH-1:0]   win_idx;

  assign requesting = req_read | req_write;

  // Pick the winning port among current requesters according to ARB_MODE.
  always_comb begin
    int cand;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == 1) begin
        // Search starts just after the previous winner and wraps around.
        cand = (int'(last_grant) + 1 + k) % NUM_PORTS;
      end else begin
        cand = k;
      end
      if (!win_found && requesting[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  // FSM: latch the winner in IDLE, hold the memory command in BUSY until mem_resp.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state           <= IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      grant_valid     <= 1'b0;
      grant_idx       <= '0;
      last_grant      <= IDX_WIDTH'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state           <= BUSY;
            // A port asking for both read and write gets a write.
            mem_write       <= req_write[win_idx];
            mem_read        <= req_read[win_idx] & ~req_write[win_idx];
            mem_address     <= req_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata       <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_byte_enable <= req_byte_enable[win_idx*BE_WIDTH +: BE_WIDTH];
            grant_valid     <= 1'b1;
            grant_idx       <= win_idx;
            last_grant      <= win_idx;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            grant_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse goes only to the owner, in the same cycle as mem_resp.
  always_comb begin
    req_resp = '0;
    if (!rst && state == BUSY && mem_resp) begin
      req_resp[grant_idx] = 1'b1;
    end
  end

  assign req_rdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester ports (legal 2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 Parameter DATA_WIDTH, default 32, data width in bits, multiple of 8; BE_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter ARB_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 One clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_read  input  NUM_PORTS  per-port read request, held until that port's req_resp.
REQ-009 req_write  input  NUM_PORTS  per-port write request, held until that port's req_resp.
REQ-010 req_address  input  NUM_PORTS*ADDR_WIDTH  per-port address, port p at slice p.
REQ-011 req_wdata  input  NUM_PORTS*DATA_WIDTH  per-port write data.
REQ-012 req_byte_enable  input  NUM_PORTS*BE_WIDTH  per-port byte enables.
REQ-013 req_resp  output  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-014 req_rdata  output  DATA_WIDTH  read data broadcast to all ports; valid only with req_resp.
REQ-015 mem_read, mem_write  output  1 each  memory commands.
REQ-016 mem_address / mem_wdata / mem_byte_enable  output  ADDR_WIDTH / DATA_WIDTH / BE_WIDTH  memory request fields.
REQ-017 mem_rdata  input  DATA_WIDTH; mem_resp  input  1  memory completion pulse.
REQ-018 grant_valid  output  1, grant_idx  output  clog2(NUM_PORTS)  current owner, for debug.

Function
REQ-019 FSM states IDLE and BUSY; exactly one memory transaction outstanding at a time.
REQ-020 IDLE: a port is requesting when req_read|req_write; if none, stay IDLE.
REQ-021 IDLE with ≥1 requester: select winner per ARB_MODE, latch its address, wdata, byte_enable and command into registers, record grant_idx, go to BUSY on the next edge.
REQ-022 mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable driven only from the latched registers; command lines asserted only in BUSY.
REQ-023 Latency: request first seen in IDLE at cycle t gives mem_read/mem_write high in cycle t+1.
REQ-024 Port asserting both req_read and req_write: write wins; mem_read stays 0.
REQ-025 BUSY holds all mem_* outputs stable until mem_resp.
REQ-026 BUSY with mem_resp=1: req_resp[grant_idx]=1 combinationally that cycle, req_rdata=mem_rdata, next state IDLE.
REQ-027 req_resp bits of non-granted ports remain 0 at all times; req_resp all 0 outside BUSY.
REQ-028 Fixed priority: lowest-indexed requesting port wins.
REQ-029 Round-robin: last_grant register; winner is first requesting port searching from last_grant+1 upward with wrap from NUM_PORTS-1 to 0; last_grant updated at grant.
REQ-030 Request withdrawn while BUSY does not abort: latched transaction completes and req_resp still pulses.
REQ-031 Requests arriving while BUSY wait; they are evaluated in the IDLE cycle after completion (one idle cycle between back-to-back transactions).
REQ-032 mem_resp while IDLE is ignored: no req_resp, no state change.
REQ-033 grant_valid=1 exactly in BUSY; grant_idx holds the latched winner.

Reset
REQ-034 rst=1 at an edge forces IDLE; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, grant_valid=0, grant_idx=0.
REQ-035 Reset sets last_grant=NUM_PORTS-1, so port 0 wins first after reset in both modes.
REQ-036 rst during BUSY drops the transaction: no req_resp for it; a later mem_resp for it is ignored per REQ-032.
REQ-037 req_resp and req_rdata are undefined (req_resp 0) while rst=1.

Verification
REQ-038 NUM_PORTS=2, ARB_MODE=0: port0 read 0x100 and port1 write 0x200 both raised at cycle 0 -> mem_read, address 0x100 at cycle 1; resp at cycle 3 -> req_resp=2'b01; then mem_write, address 0x200 at cycle 5.
REQ-039 ARB_MODE=1, NUM_PORTS=4, all ports requesting continuously -> grants in order 0,1,2,3,0; each mem_resp pulses only the matching req_resp bit.
REQ-040 Port1 write 0xDEADBEEF, byte_enable 4'b0011 -> mem_wdata=0xDEADBEEF, mem_byte_enable=4'b0011 held stable for all BUSY cycles until mem_resp.
REQ-041 Read with mem_rdata=0x12345678 on the mem_resp cycle -> req_rdata=0x12345678 and req_resp pulse in that same cycle, one cycle wide.
REQ-042 rst asserted in cycle 2 of a BUSY read, then mem_resp in cycle 4 -> mem_read=0 from cycle 3, no req_resp, grant_valid=0.
REQ-043 Spurious mem_resp with no requests pending -> all req_resp remain 0; FSM stays IDLE.
